// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the core and the loader,
// sequences instruction-memory fences and counts writes between fences.
module dm_arbiter #(
  parameter bit PRIO_CORE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_c_req,
  input  logic        i_c_wen,
  input  logic [3:0]  i_c_ben,
  input  logic [13:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_l_req,
  input  logic        i_l_wen,
  input  logic [3:0]  i_l_ben,
  input  logic [13:0] i_l_addr,
  input  logic [31:0] i_l_wdata,
  output logic        o_l_gnt,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  input  logic        i_l_fence,
  output logic        o_l_fence_done,
  output logic        o_dm_ren,
  output logic        o_dm_wen,
  output logic [3:0]  o_dm_ben,
  output logic [13:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata,
  output logic        o_fence_i,
  input  logic        i_ready,
  output logic [7:0]  o_wr_cnt
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FENCE_ISSUE  = 2'd1,
    FENCE_DRAIN  = 2'd2,
    FENCE_RESUME = 2'd3
  } state_e;

  state_e      state_q;
  logic        last_l_q;
  logic        rd_pend_q;
  logic        rd_own_l_q;
  logic [7:0]  wr_cnt_q;
  logic [7:0]  wr_cnt_d;
  logic        gnt_en_s;
  logic        c_gnt_s;
  logic        l_gnt_s;
  logic        any_gnt_s;
  logic        gnt_wen_s;

  // Gating with i_rst_n makes grants and the memory port drop the instant reset asserts.
  assign gnt_en_s  = i_rst_n && (state_q == RUN) && i_ready && !i_l_fence;
  assign any_gnt_s = c_gnt_s | l_gnt_s;
  assign gnt_wen_s = l_gnt_s ? i_l_wen : i_c_wen;

  always_comb begin
    c_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (gnt_en_s) begin
      if (i_c_req && i_l_req) begin
        if (PRIO_CORE || last_l_q) begin
          c_gnt_s = 1'b1;
        end else begin
          l_gnt_s = 1'b1;
        end
      end else begin
        c_gnt_s = i_c_req;
        l_gnt_s = i_l_req;
      end
    end else begin
      c_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end
  end

  always_comb begin
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = 4'h0;
    o_dm_addr  = 14'h0;
    o_dm_wdata = 32'h0;
    if (c_gnt_s) begin
      o_dm_ren   = !i_c_wen;
      o_dm_wen   = i_c_wen;
      o_dm_ben   = i_c_ben;
      o_dm_addr  = i_c_addr;
      o_dm_wdata = i_c_wdata;
    end else if (l_gnt_s) begin
      o_dm_ren   = !i_l_wen;
      o_dm_wen   = i_l_wen;
      o_dm_ben   = i_l_ben;
      o_dm_addr  = i_l_addr;
      o_dm_wdata = i_l_wdata;
    end else begin
      o_dm_ren   = 1'b0;
      o_dm_wen   = 1'b0;
      o_dm_ben   = 4'h0;
      o_dm_addr  = 14'h0;
      o_dm_wdata = 32'h0;
    end
  end

  // The counter clears on fence entry, so it already reads 0 throughout FENCE_ISSUE.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if ((state_q == RUN) && i_l_fence) begin
      wr_cnt_d = 8'd0;
    end else if (any_gnt_s && gnt_wen_s && (wr_cnt_q != 8'hFF)) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:          if (i_l_fence) state_q <= FENCE_ISSUE;
        FENCE_ISSUE:  state_q <= FENCE_DRAIN;
        FENCE_DRAIN:  if (!i_ready) state_q <= FENCE_RESUME;
        FENCE_RESUME: if (i_ready) state_q <= RUN;
        default:      state_q <= RUN;
      endcase
    end
  end

  // last_l_q resets to "loader" so the core wins the first contended cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_l_q   <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_own_l_q <= 1'b0;
      wr_cnt_q   <= 8'd0;
    end else begin
      if (any_gnt_s) begin
        last_l_q <= l_gnt_s;
      end
      rd_pend_q  <= any_gnt_s && !gnt_wen_s;
      rd_own_l_q <= l_gnt_s;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign o_c_gnt        = c_gnt_s;
  assign o_l_gnt        = l_gnt_s;
  assign o_c_rvalid     = rd_pend_q && !rd_own_l_q;
  assign o_l_rvalid     = rd_pend_q && rd_own_l_q;
  assign o_c_rdata      = o_c_rvalid ? i_dm_rdata : 32'h0;
  assign o_l_rdata      = o_l_rvalid ? i_dm_rdata : 32'h0;
  assign o_fence_i      = (state_q == FENCE_ISSUE);
  assign o_l_fence_done = (state_q == FENCE_RESUME) && i_ready;
  assign o_wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus pushes expected grants and read
// returns; an independent monitor compares them on every falling edge.
module tb_dm_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_c_req, i_c_wen, i_l_req, i_l_wen, i_l_fence, i_ready;
  logic [3:0]  i_c_ben, i_l_ben;
  logic [13:0] i_c_addr, i_l_addr;
  logic [31:0] i_c_wdata, i_l_wdata, i_dm_rdata;

  logic        o_c_gnt, o_c_rvalid, o_l_gnt, o_l_rvalid, o_l_fence_done;
  logic [31:0] o_c_rdata, o_l_rdata, o_dm_wdata;
  logic        o_dm_ren, o_dm_wen, o_fence_i;
  logic [3:0]  o_dm_ben;
  logic [13:0] o_dm_addr;
  logic [7:0]  o_wr_cnt;

  logic        fp_c_gnt, fp_c_rvalid, fp_l_gnt, fp_l_rvalid, fp_l_fence_done;
  logic [31:0] fp_c_rdata, fp_l_rdata, fp_dm_wdata;
  logic        fp_dm_ren, fp_dm_wen, fp_fence_i;
  logic [3:0]  fp_dm_ben;
  logic [13:0] fp_dm_addr;
  logic [7:0]  fp_wr_cnt;

  dm_arbiter #(.PRIO_CORE(1'b0)) u_rr (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_req(i_c_req), .i_c_wen(i_c_wen), .i_c_ben(i_c_ben), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
    .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata),
    .i_l_req(i_l_req), .i_l_wen(i_l_wen), .i_l_ben(i_l_ben), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_gnt(o_l_gnt), .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata),
    .i_l_fence(i_l_fence), .o_l_fence_done(o_l_fence_done),
    .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
    .i_dm_rdata(i_dm_rdata), .o_fence_i(o_fence_i), .i_ready(i_ready), .o_wr_cnt(o_wr_cnt)
  );

  dm_arbiter #(.PRIO_CORE(1'b1)) u_fp (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_req(i_c_req), .i_c_wen(i_c_wen), .i_c_ben(i_c_ben), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
    .o_c_gnt(fp_c_gnt), .o_c_rvalid(fp_c_rvalid), .o_c_rdata(fp_c_rdata),
    .i_l_req(i_l_req), .i_l_wen(i_l_wen), .i_l_ben(i_l_ben), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_gnt(fp_l_gnt), .o_l_rvalid(fp_l_rvalid), .o_l_rdata(fp_l_rdata),
    .i_l_fence(i_l_fence), .o_l_fence_done(fp_l_fence_done),
    .o_dm_ren(fp_dm_ren), .o_dm_wen(fp_dm_wen), .o_dm_ben(fp_dm_ben), .o_dm_addr(fp_dm_addr), .o_dm_wdata(fp_dm_wdata),
    .i_dm_rdata(i_dm_rdata), .o_fence_i(fp_fence_i), .i_ready(i_ready), .o_wr_cnt(fp_wr_cnt)
  );

  typedef struct packed {
    logic        lo;
    logic        wen;
    logic [3:0]  ben;
    logic [13:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        lo;
    logic [31:0] data;
    logic [31:0] cyc;
  } rv_t;

  gnt_t        gq[$];
  rv_t         rq[$];
  logic [31:0] cyc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        exp_fi, exp_fd, chk_cnt, chk_fp, chk_zero, exp_fp_c, exp_fp_l;
  logic [7:0]  exp_cnt;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 32'd1;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {16'hBEEF, 2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each falling edge, compare the DUT against whatever the stimulus queued.
  initial begin : monitor
    gnt_t g;
    rv_t  r;
    forever begin
      @(negedge i_clk);
      if (gq.size() != 0) begin
        g = gq.pop_front();
        chk("grant", {o_c_gnt, o_l_gnt, o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata},
                     {~g.lo, g.lo, ~g.wen, g.wen, g.ben, g.addr, g.wdata});
      end else begin
        chk("no_grant", {o_c_gnt, o_l_gnt, o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata}, 160'h0);
      end
      if ((rq.size() != 0) && (rq[0].cyc == cyc)) begin
        r = rq.pop_front();
        chk("rvalid", {o_c_rvalid, o_l_rvalid, o_c_rdata, o_l_rdata},
                      {~r.lo, r.lo, (r.lo ? 32'h0 : r.data), (r.lo ? r.data : 32'h0)});
      end else begin
        chk("no_rvalid", {o_c_rvalid, o_l_rvalid, o_c_rdata, o_l_rdata}, 160'h0);
      end
      chk("fence_i", {159'h0, o_fence_i}, {159'h0, exp_fi});
      chk("fence_done", {159'h0, o_l_fence_done}, {159'h0, exp_fd});
      if (chk_cnt) chk("wr_cnt", {152'h0, o_wr_cnt}, {152'h0, exp_cnt});
      if (chk_fp) chk("fp_gnt", {fp_c_gnt, fp_l_gnt, fp_dm_addr}, {exp_fp_c, exp_fp_l, 14'h0010});
      if (chk_zero)
        chk("reset_outs", {o_c_gnt, o_l_gnt, o_c_rvalid, o_l_rvalid, o_c_rdata, o_l_rdata, o_l_fence_done,
                           o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata, o_fence_i, o_wr_cnt}, 160'h0);
    end
  end

  task automatic clear_exp();
    exp_fi = 1'b0; exp_fd = 1'b0; chk_cnt = 1'b0; chk_fp = 1'b0; chk_zero = 1'b0;
    exp_fp_c = 1'b0; exp_fp_l = 1'b0; exp_cnt = 8'd0;
  endtask

  // Advance one cycle; the memory model returns read data one cycle after a read.
  task automatic step();
    logic        ren;
    logic [13:0] a;
    @(negedge i_clk);
    ren = o_dm_ren;
    a   = o_dm_addr;
    @(posedge i_clk);
    #1;
    i_dm_rdata = ren ? mem_word(a) : 32'h0;
    clear_exp();
  endtask

  task automatic drive_c(input logic req, input logic wen, input logic [3:0] ben,
                         input logic [13:0] addr, input logic [31:0] wdata);
    i_c_req = req; i_c_wen = wen; i_c_ben = ben; i_c_addr = addr; i_c_wdata = wdata;
  endtask

  task automatic drive_l(input logic req, input logic wen, input logic [3:0] ben,
                         input logic [13:0] addr, input logic [31:0] wdata);
    i_l_req = req; i_l_wen = wen; i_l_ben = ben; i_l_addr = addr; i_l_wdata = wdata;
  endtask

  task automatic expect_gnt(input logic lo);
    gnt_t g;
    rv_t  r;
    g.lo    = lo;
    g.wen   = lo ? i_l_wen   : i_c_wen;
    g.ben   = lo ? i_l_ben   : i_c_ben;
    g.addr  = lo ? i_l_addr  : i_c_addr;
    g.wdata = lo ? i_l_wdata : i_c_wdata;
    gq.push_back(g);
    if (!g.wen) begin
      r.lo = lo; r.data = mem_word(g.addr); r.cyc = cyc + 32'd1;
      rq.push_back(r);
    end
  endtask

  initial begin : stimulus
    logic [3:0] rr_seq;
    clear_exp();
    i_rst_n = 1'b0; i_ready = 1'b1; i_l_fence = 1'b0; i_dm_rdata = 32'h0;
    drive_c(1'b1, 1'b0, 4'hF, 14'h0010, 32'h1111_1111);
    drive_l(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    chk_zero = 1'b1;
    step();

    // Contention: round-robin C,L,C,L; fixed-priority instance always core.
    i_rst_n = 1'b1;
    rr_seq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      drive_c(1'b1, 1'b0, 4'hF, 14'h0010, 32'h1111_1111);
      drive_l(1'b1, 1'b0, 4'h3, 14'h0020, 32'h2222_2222);
      expect_gnt(rr_seq[i]);
      chk_fp = 1'b1; exp_fp_c = 1'b1; exp_fp_l = 1'b0;
      step();
    end
    drive_c(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    drive_l(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    step();

    // Three loader writes, then a fence while the core keeps requesting.
    for (int i = 0; i < 3; i++) begin
      drive_l(1'b1, 1'b1, 4'hC, 14'h0100 + 14'(i), 32'hA000_0000 + 32'(i));
      chk_cnt = 1'b1; exp_cnt = 8'(i);
      expect_gnt(1'b1);
      step();
    end
    drive_l(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    drive_c(1'b1, 1'b1, 4'hF, 14'h0040, 32'hC0DE_0040);
    i_l_fence = 1'b1;
    chk_cnt = 1'b1; exp_cnt = 8'd3;
    step();
    exp_fi = 1'b1; chk_cnt = 1'b1; exp_cnt = 8'd0;
    step();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    i_ready = 1'b1; exp_fd = 1'b1;
    step();
    i_l_fence = 1'b0;
    chk_cnt = 1'b1; exp_cnt = 8'd0;
    expect_gnt(1'b0);
    step();
    drive_c(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    chk_cnt = 1'b1; exp_cnt = 8'd1;
    step();

    // Memory stall: three blocked cycles, grant when i_ready returns.
    i_ready = 1'b0;
    drive_c(1'b1, 1'b1, 4'h5, 14'h0050, 32'h5555_0050);
    for (int i = 0; i < 3; i++) step();
    i_ready = 1'b1;
    chk_cnt = 1'b1; exp_cnt = 8'd1;
    expect_gnt(1'b0);
    step();

    // Saturation: 300 further core writes, counter stops at 255.
    for (int i = 0; i < 300; i++) begin
      drive_c(1'b1, 1'b1, 4'hF, 14'(i), 32'(i));
      chk_cnt = 1'b1; exp_cnt = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      expect_gnt(1'b0);
      step();
    end
    drive_c(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    chk_cnt = 1'b1; exp_cnt = 8'd255;
    step();

    // Read in flight at reset: no rvalid may follow.
    drive_c(1'b1, 1'b0, 4'hF, 14'h0060, 32'h0);
    expect_gnt(1'b0);
    step();
    drive_c(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    i_rst_n = 1'b0;
    rq.delete();
    chk_zero = 1'b1;
    step();
    i_rst_n = 1'b1;
    step();

    // Reset in FENCE_DRAIN aborts the fence; core read granted straight after.
    i_l_fence = 1'b1;
    step();
    exp_fi = 1'b1;
    step();
    i_ready = 1'b0; i_l_fence = 1'b0; i_rst_n = 1'b0;
    drive_c(1'b1, 1'b0, 4'hF, 14'h0070, 32'h0);
    chk_zero = 1'b1;
    step();
    i_rst_n = 1'b1; i_ready = 1'b1;
    expect_gnt(1'b0);
    step();
    drive_c(1'b0, 1'b0, 4'h0, 14'h0000, 32'h0);
    for (int i = 0; i < 3; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter PRIO_CORE, default 0: 0 selects round-robin arbitration, 1 selects fixed priority for the core.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 i_clk  in  1  sole clock; all state is updated on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_c_req / i_c_wen  in  1/1  core access request / write (0 = read).
REQ-006 i_c_ben / i_c_addr / i_c_wdata  in  4/14/32  core byte enables / word address / write data.
REQ-007 o_c_gnt / o_c_rvalid / o_c_rdata  out  1/1/32  core grant / read-data valid / read data.
REQ-008 i_l_req / i_l_wen / i_l_ben / i_l_addr / i_l_wdata  in  1/1/4/14/32  loader request fields, same meaning as the core fields.
REQ-009 o_l_gnt / o_l_rvalid / o_l_rdata  out  1/1/32  loader grant / read-data valid / read data.
REQ-010 i_l_fence  in  1  level; loader requests an instruction-memory sync.
REQ-011 o_l_fence_done  out  1  one-cycle pulse; the sync has completed.
REQ-012 o_dm_ren / o_dm_wen / o_dm_ben / o_dm_addr / o_dm_wdata  out  1/1/4/14/32  data-memory port.
REQ-013 i_dm_rdata  in  32  data-memory read data, valid 1 cycle after the read.
REQ-014 o_fence_i  out  1  sync strobe to memory.
REQ-015 i_ready  in  1  memory accepts accesses.
REQ-016 o_wr_cnt  out  8  granted writes since the last fence, saturating.

Function
REQ-017 FSM states: RUN, FENCE_ISSUE, FENCE_DRAIN, FENCE_RESUME.
REQ-018 Grant conditions: a grant SHALL occur only when the state is RUN, i_ready=1, and i_l_fence=0.
REQ-019 Grant timing: o_c_gnt/o_l_gnt SHALL be combinational, asserted in the same cycle the access is driven; at most one grant per cycle.
REQ-020 Round-robin (PRIO_CORE=0): with both requesting, grant the requester not granted last; with a single requester, grant it.
REQ-021 Pointer update: the last-grant pointer SHALL update only on a grant.
REQ-022 Fixed priority (PRIO_CORE=1): the core SHALL win whenever both requests are asserted.
REQ-023 Port drive on a grant: o_dm_* SHALL carry the granted requester's fields; o_dm_ren=!wen, o_dm_wen=wen.
REQ-024 Port drive without a grant: o_dm_ren=0, o_dm_wen=0, o_dm_ben=0, o_dm_addr=0, o_dm_wdata=0.
REQ-025 Read return: a granted read SHALL assert the owner's rvalid exactly 1 cycle later, with rdata=i_dm_rdata.
REQ-026 Read routing: the owner SHALL be taken from a registered tag; the non-owner's rvalid=0 and its rdata=0.
REQ-027 Write completion: granted writes SHALL produce no rvalid.
REQ-028 Fence entry: in RUN with i_l_fence=1 (priority over all requests), the FSM SHALL go to FENCE_ISSUE.
REQ-029 FENCE_ISSUE: o_fence_i=1 for exactly one cycle, o_dm_wen=0, no grant; then go to FENCE_DRAIN.
REQ-030 FENCE_DRAIN: stay until i_ready=0 is sampled, then go to FENCE_RESUME.
REQ-031 FENCE_RESUME: stay until i_ready=1; on that cycle pulse o_l_fence_done and go to RUN.
REQ-032 Fence blocking: no grants SHALL occur outside RUN.
REQ-033 Fence hold: the loader SHALL drop i_l_fence on fence_done; if i_l_fence is still 1 in the following RUN cycle, a new fence starts.
REQ-034 o_wr_cnt SHALL increment on each granted write, saturate at 255, and clear to 0 in FENCE_ISSUE.
REQ-035 Simultaneous read and fence: a read granted in the cycle before FENCE_ISSUE SHALL still return its rvalid in the FENCE_ISSUE cycle.
REQ-036 Memory stall: i_ready=0 in RUN blocks all grants; requesters SHALL hold their request fields until granted.

Reset
REQ-037 Asynchronous assertion of i_rst_n=0 SHALL immediately force state=RUN, all grants=0, all rvalids=0, o_fence_i=0, o_l_fence_done=0, o_wr_cnt=0, read tag cleared.
REQ-038 The last-grant pointer SHALL reset to "loader" so the core wins the first contended cycle.
REQ-039 Reset during FENCE_DRAIN or FENCE_RESUME SHALL abort the fence with no fence_done pulse.
REQ-040 A read in flight at reset SHALL produce no rvalid after reset.
REQ-041 Reset release SHALL be synchronised externally; the block samples normally from the first rising edge with i_rst_n=1.

Verification
REQ-042 Contention: reset, i_ready=1, both requesting reads at addr 0x0010 (core) and 0x0020 (loader) for 4 cycles -> grants C,L,C,L; each rvalid goes to the matching owner 1 cycle later with the matching rdata.
REQ-043 Fixed priority: PRIO_CORE=1, same stimulus as REQ-042 -> the core is granted all 4 cycles, the loader none.
REQ-044 Fence sequence: 3 loader writes, then i_l_fence=1; memory model drops i_ready for 5 cycles starting 1 cycle after o_fence_i -> o_wr_cnt=3 before the fence and 0 after; o_fence_i is a single pulse; fence_done on the first i_ready=1; no grants in between.
REQ-045 Saturation: 300 core writes with no fence -> o_wr_cnt=255.
REQ-046 Stall: i_ready=0 for 3 cycles while the core requests -> no grant and o_dm_wen=0 for those cycles; the grant occurs in the cycle i_ready returns to 1.
REQ-047 Reset in fence: assert i_rst_n=0 in FENCE_DRAIN -> all outputs 0 at once; after release, a core read is granted in the first cycle and no fence_done is ever seen.
